// File: rtl/crc32_checker.sv
// Serial CRC-32 frame checker: runs the generator's LFSR over message + CRC bits
// and flags the frame good on a zero residue. Optional macro: CRC32_CHECKER_RXCRC_EN.
module crc32_checker #(
  parameter logic [31:0] POLY     = 32'h04C11DB7,
  parameter int          MIN_BITS = 33,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             too_short,
  output logic             abort,
  output logic [CNT_W-1:0] frame_bits,
  output logic [31:0]      remainder,
  output logic [CNT_W-1:0] err_cnt
`ifdef CRC32_CHECKER_RXCRC_EN
  ,
  output logic [31:0]      rx_crc
`endif
);

  // Handshake: a bit (with its sof/eof marks) is taken on any rising edge where
  // in_valid=1; there is no back-pressure, so the upstream never stalls.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_BITS);

  function automatic logic [31:0] crc_step(input logic [31:0] r, input logic b);
    logic fb;
    fb = r[31] ^ b;
    return {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_err_q, crc_err_d;
  logic             short_q, short_d;
  logic [CNT_W-1:0] fbits_q, fbits_d;
  logic [31:0]      rem_q, rem_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             eof_hit;
  logic             pass;
`ifdef CRC32_CHECKER_RXCRC_EN
  logic [31:0]      rx_sh_q, rx_sh_d;
  logic [31:0]      rx_crc_q, rx_crc_d;
`endif

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    crc_ok_d  = crc_ok_q;
    crc_err_d = crc_err_q;
    short_d   = short_q;
    fbits_d   = fbits_q;
    rem_d     = rem_q;
    err_cnt_d = err_cnt_q;
    eof_hit   = 1'b0;
    pass      = 1'b0;
`ifdef CRC32_CHECKER_RXCRC_EN
    rx_sh_d   = rx_sh_q;
    rx_crc_d  = rx_crc_q;
`endif

    if (in_valid) begin
      if (in_sof) begin
        // A sof always (re)starts a frame; in RECV the open frame is dropped.
        abort_d = (state_q == ST_RECV);
        lfsr_d  = crc_step(32'h0, in_bit);
        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        ovf_d   = 1'b0;
        state_d = ST_RECV;
        eof_hit = in_eof;
`ifdef CRC32_CHECKER_RXCRC_EN
        rx_sh_d = {31'h0, in_bit};
`endif
      end else if (state_q == ST_RECV) begin
        lfsr_d = crc_step(lfsr_q, in_bit);
        if (cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        eof_hit = in_eof;
`ifdef CRC32_CHECKER_RXCRC_EN
        rx_sh_d = {rx_sh_q[30:0], in_bit};
`endif
      end
    end

    // Results are captured on the eof edge itself so done lands one clock later.
    if (eof_hit) begin
      state_d   = ST_IDLE;
      done_d    = 1'b1;
      fbits_d   = cnt_d;
      rem_d     = lfsr_d;
      short_d   = (cnt_d < CNT_MIN);
      pass      = (lfsr_d == 32'h0) && !short_d && !ovf_d;
      crc_ok_d  = pass;
      crc_err_d = !pass;
      if (!pass && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
`ifdef CRC32_CHECKER_RXCRC_EN
      rx_crc_d  = rx_sh_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= 32'h0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      short_q   <= 1'b0;
      fbits_q   <= '0;
      rem_q     <= 32'h0;
      err_cnt_q <= '0;
`ifdef CRC32_CHECKER_RXCRC_EN
      rx_sh_q   <= 32'h0;
      rx_crc_q  <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      crc_ok_q  <= crc_ok_d;
      crc_err_q <= crc_err_d;
      short_q   <= short_d;
      fbits_q   <= fbits_d;
      rem_q     <= rem_d;
      err_cnt_q <= err_cnt_d;
`ifdef CRC32_CHECKER_RXCRC_EN
      rx_sh_q   <= rx_sh_d;
      rx_crc_q  <= rx_crc_d;
`endif
    end
  end

  assign busy       = (state_q == ST_RECV);
  assign done       = done_q;
  assign abort      = abort_q;
  assign crc_ok     = crc_ok_q;
  assign crc_err    = crc_err_q;
  assign too_short  = short_q;
  assign frame_bits = fbits_q;
  assign remainder  = rem_q;
  assign err_cnt    = err_cnt_q;
`ifdef CRC32_CHECKER_RXCRC_EN
  assign rx_crc     = rx_crc_q;
`endif

endmodule

// File: tb/tb_crc32_checker.sv
// Directed bench for crc32_checker: known-good/bad frames, gaps, short frames,
// abort, mid-frame reset and back-to-back frames, checked with immediate assertions.
module tb_crc32_checker;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             in_sof = 1'b0;
  logic             in_eof = 1'b0;
  logic             busy, done, crc_ok, crc_err, too_short, abort;
  logic [CNT_W-1:0] frame_bits, err_cnt;
  logic [31:0]      remainder;
`ifdef CRC32_CHECKER_RXCRC_EN
  logic [31:0]      rx_crc;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  int abort_seen = 0;

  crc32_checker dut (
    .clk        (clk),
    .clrn       (clrn),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .too_short  (too_short),
    .abort      (abort),
    .frame_bits (frame_bits),
    .remainder  (remainder),
    .err_cnt    (err_cnt)
`ifdef CRC32_CHECKER_RXCRC_EN
    ,
    .rx_crc     (rx_crc)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done) done_seen++;
    if (abort) abort_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends n bits of frame MSB-first; one idle cycle is inserted before bit
  // positions g0/g1/g2 (counted from the frame start, -1 = none).
  task automatic send_frame(input logic [63:0] frame, input int n, input bit with_eof,
                            input int g0, input int g1, input int g2);
    for (int i = n - 1; i >= 0; i--) begin
      int pos;
      pos = n - 1 - i;
      if (pos == g0 || pos == g1 || pos == g2) idle(1);
      in_valid = 1'b1;
      in_bit   = frame[i];
      in_sof   = (i == n - 1);
      in_eof   = with_eof && (i == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  localparam logic [63:0] GOOD = 64'h1_04C11DB7;
  localparam logic [63:0] BAD  = 64'h1_04C11DB6;

  int d0, a0, c0, c1, gp;

  initial begin
    // Reset
    clrn = 1'b0;
    idle(3);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ok", 32'(crc_ok), 32'h0);
    check("rst_err", 32'(crc_err), 32'h0);
    check("rst_rem", remainder, 32'h0);
    check("rst_errcnt", 32'(err_cnt), 32'h0);
    clrn = 1'b1;
    idle(2);

    // 1: good 33-bit frame
    d0 = done_seen;
    send_frame(GOOD, 33, 1'b1, -1, -1, -1);
    check("t1_done", 32'(done), 32'h1);
    check("t1_ok", 32'(crc_ok), 32'h1);
    check("t1_err", 32'(crc_err), 32'h0);
    check("t1_rem", remainder, 32'h0);
    check("t1_bits", 32'(frame_bits), 32'd33);
    check("t1_errcnt", 32'(err_cnt), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    idle(1);
    check("t1_pulse", 32'(done), 32'h0);
    check("t1_ndone", 32'(done_seen - d0), 32'd1);
    check("t1_hold", 32'(crc_ok), 32'h1);
`ifdef CRC32_CHECKER_RXCRC_EN
    check("t1_rxcrc", rx_crc, 32'h04C11DB7);
`endif

    // 2: last bit inverted
    send_frame(BAD, 33, 1'b1, -1, -1, -1);
    check("t2_err", 32'(crc_err), 32'h1);
    check("t2_ok", 32'(crc_ok), 32'h0);
    check("t2_rem", remainder, 32'h04C11DB7);
    check("t2_errcnt", 32'(err_cnt), 32'h1);
    idle(2);

    // 3: 40 zero bits with three random idle cycles mid-frame
    gp = $urandom_range(30, 2);
    send_frame(64'h0, 40, 1'b1, gp, gp + 3, gp + 7);
    check("t3_ok", 32'(crc_ok), 32'h1);
    check("t3_bits", 32'(frame_bits), 32'd40);
    check("t3_rem", remainder, 32'h0);
    check("t3_errcnt", 32'(err_cnt), 32'h1);
    idle(2);

    // 4: 20-bit all-zero frame is too short
    send_frame(64'h0, 20, 1'b1, -1, -1, -1);
    check("t4_short", 32'(too_short), 32'h1);
    check("t4_err", 32'(crc_err), 32'h1);
    check("t4_rem", remainder, 32'h0);
    check("t4_bits", 32'(frame_bits), 32'd20);
    check("t4_errcnt", 32'(err_cnt), 32'h2);
    idle(2);

    // sof and eof on the same bit
    send_frame(64'h0, 1, 1'b1, -1, -1, -1);
    check("one_done", 32'(done), 32'h1);
    check("one_short", 32'(too_short), 32'h1);
    check("one_err", 32'(crc_err), 32'h1);
    check("one_bits", 32'(frame_bits), 32'd1);
    check("one_errcnt", 32'(err_cnt), 32'h3);
    idle(2);

    // 5: abort an open frame with a new sof
    a0 = abort_seen;
    d0 = done_seen;
    send_frame(64'h3FF, 10, 1'b0, -1, -1, -1);
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_keep", 32'(frame_bits), 32'd1);
    send_frame(GOOD, 33, 1'b1, -1, -1, -1);
    check("t5_ok", 32'(crc_ok), 32'h1);
    check("t5_bits", 32'(frame_bits), 32'd33);
    check("t5_errcnt", 32'(err_cnt), 32'h3);
    idle(2);
    check("t5_abort", 32'(abort_seen - a0), 32'd1);
    check("t5_ndone", 32'(done_seen - d0), 32'd1);

    // 5b: reset during a frame
    d0 = done_seen;
    send_frame(GOOD, 12, 1'b0, -1, -1, -1);
    clrn = 1'b0;
    idle(2);
    clrn = 1'b1;
    idle(2);
    check("t5r_ndone", 32'(done_seen - d0), 32'd0);
    check("t5r_busy", 32'(busy), 32'h0);
    check("t5r_ok", 32'(crc_ok), 32'h0);
    check("t5r_bits", 32'(frame_bits), 32'h0);
    check("t5r_errcnt", 32'(err_cnt), 32'h0);

    // 6: back-to-back good frames, second sof in the done cycle
    send_frame(GOOD, 33, 1'b1, -1, -1, -1);
    c0 = cyc;
    check("t6_done1", 32'(done), 32'h1);
    check("t6_ok1", 32'(crc_ok), 32'h1);
    send_frame(GOOD, 33, 1'b1, -1, -1, -1);
    c1 = cyc;
    check("t6_done2", 32'(done), 32'h1);
    check("t6_ok2", 32'(crc_ok), 32'h1);
    check("t6_gap", 32'(c1 - c0), 32'd33);
    check("t6_errcnt", 32'(err_cnt), 32'h0);
`ifdef CRC32_CHECKER_RXCRC_EN
    check("t6_rxcrc", rx_crc, 32'h04C11DB7);
`endif
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc32_checker.md
Name: crc32_checker

Overview:
- Serial CRC-32 receiver and checker; the receiving end of the serial crc32 generator.
- Accepts a framed bit stream, MSB-first: message bits followed by the 32 CRC bits the generator produced.
- Runs the same LFSR over the whole frame and reports pass/fail from a zero residue.
- Sits behind a bit-level deserializer and feeds a frame status register block.

Parameters:
POLY, 32'h04C11DB7, generator polynomial (x^32 term implicit)
MIN_BITS, 33, minimum legal frame length in bits (message >=1 bit + 32 CRC bits)
CNT_W, 16, width of frame bit counter and error counter

Ports:
clk  input  1  clock, all state updates on rising edge
clrn  input  1  reset, synchronous, active-low
in_valid  input  1  in_bit/in_sof/in_eof qualified this cycle
in_bit  input  1  serial data bit, MSB-first
in_sof  input  1  first bit of frame (valid only with in_valid)
in_eof  input  1  last bit of frame, i.e. last CRC bit (valid only with in_valid)
busy  output  1  frame in progress
done  output  1  one-cycle pulse, result outputs updated
crc_ok  output  1  last frame passed
crc_err  output  1  last frame failed (bad residue, too short, or counter overflow)
too_short  output  1  last frame shorter than MIN_BITS
abort  output  1  one-cycle pulse, open frame discarded by a new in_sof
frame_bits  output  CNT_W  bit count of last completed frame
remainder  output  32  LFSR residue of last completed frame
err_cnt  output  CNT_W  saturating count of failed frames

Behaviour:
- Reset (clrn=0 at a clk edge): state=IDLE, LFSR=0, all outputs 0. Reset mid-frame discards the frame: no done, no err_cnt change.
- LFSR update per accepted bit b:
  - fb = r[31]^b
  - r_next = {r[30:0],1'b0} ^ (fb ? POLY : 0)
  - This matches the generator, so a correct frame leaves residue 0.
- A bit is accepted only when in_valid=1. When in_valid=0, all state holds.
- IDLE:
  - in_valid & in_sof: LFSR loads update(0, in_bit); counter=1; go to RECV; busy=1 next cycle.
  - in_valid without in_sof: ignored.
- RECV:
  - in_valid & !in_sof: LFSR updates; counter increments, saturating at 2^CNT_W-1 with a sticky overflow flag.
  - in_valid & in_sof: pulse abort next cycle; restart the frame with this bit, as in IDLE. Previous results are untouched.
- End of frame: in_valid & in_eof, in IDLE together with sof or in RECV.
  - That bit is processed.
  - Next cycle: done=1 for one cycle; frame_bits and remainder registered; busy=0; state=IDLE.
  - too_short = (count < MIN_BITS).
  - crc_ok = (remainder==0) & !too_short & !overflow; crc_err = !crc_ok.
  - err_cnt += crc_err, saturating at all-ones.
- sof & eof on the same bit: 1-bit frame, too_short=1, crc_err=1.
- crc_ok, crc_err, too_short, frame_bits and remainder hold until the next done or reset.
- A new frame may start the cycle done is high (back-to-back frames, no dead cycle).
- Latency: done asserts exactly 1 clk after the eof bit is sampled.

Optional Feature:
- Macro: CRC32_CHECKER_RXCRC_EN.
- Defined:
  - Adds output rx_crc[31:0], a shift register of the last 32 accepted bits of the frame (the received CRC field), cleared at sof.
  - rx_crc is registered alongside remainder at done.
  - Reset value 0.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
1. Frame = bit 1 then 32'h04C11DB7 MSB-first (33 bits, sof on first, eof on last) -> done 1 clk after eof, crc_ok=1, remainder=0, frame_bits=33, err_cnt=0.
2. Same frame with last bit inverted -> crc_err=1, remainder=32'h04C11DB7, err_cnt=1.
3. Frame = 8'h00 + 32'h00000000 (40 bits) with in_valid deasserted for 3 random cycles mid-frame -> crc_ok=1, frame_bits=40.
4. 20-bit frame, all zeros -> too_short=1, crc_err=1, remainder=0, err_cnt increments.
5. Start frame, 10 bits, then new sof with test 1 frame -> abort pulse once; result crc_ok=1, frame_bits=33. clrn=0 during a later frame -> no done, all outputs 0.
6. Two test-1 frames back-to-back (second sof on the done cycle) -> two done pulses 33 clks apart, both crc_ok=1. With CRC32_CHECKER_RXCRC_EN, rx_crc=32'h04C11DB7.
